// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and constants for the XOR gate test sequencer.
package gate_test_pkg;

    // Sequencer state encoding; also exported on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Width of the settle counter; holds SETTLE-1 for SETTLE up to 15.
    localparam int SETTLE_W = 4;

endpackage : gate_test_pkg

// File: rtl/gate_test_sequencer_if.sv
// Control/stimulus bundle between the harness and the gate test sequencer.
//
// Handshake: start is a request level sampled only while the sequencer is
// idle or done (busy=0); a request accepted on a clock edge raises busy on
// the next cycle, and further start pulses are ignored while busy=1. done is
// the completion flag: it stays high (with pass/err_count/first_fail stable)
// until the next accepted start, an abort, or reset. abort is accepted in any
// state and wins over start.
interface gate_test_sequencer_if import gate_test_pkg::*; #(
    parameter int WIDTH = 2
) ();

    logic             start;
    logic             abort;
    logic             dut_out;
    logic [WIDTH-1:0] stim;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH:0]   err_count;
    logic [WIDTH-1:0] first_fail;
    state_e           dbg_state;

    // Harness side: issues commands and returns the gate output.
    modport master (
        output start, abort, dut_out,
        input  stim, busy, done, pass, err_count, first_fail, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  start, abort, dut_out,
        output stim, busy, done, pass, err_count, first_fail, dbg_state
    );

endinterface : gate_test_sequencer_if

// File: rtl/gate_test_sequencer_settle_timer.sv
// Loadable down-counter that times how long each vector settles.
module settle_timer import gate_test_pkg::*; #(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : settle_timer

// File: rtl/gate_test_sequencer.sv
// Sweeps an XOR gate-under-test through its whole truth table in ascending
// order, holds each vector for SETTLE cycles, checks the gate output in a
// single CHECK cycle, and reports error count, first failing vector and pass.
module gate_test_sequencer import gate_test_pkg::*; #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input logic                  clk,
    input logic                  rst,
    gate_test_sequencer_if.slave bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0]    STIM_LAST   = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic [WIDTH-1:0] first_fail_q, first_fail_d;
    logic [WIDTH:0]   err_q, err_d;
    logic             pass_q, pass_d;

    logic start_ok;
    logic last_vec;
    logic mismatch;
    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    // A start only counts when not busy and not overridden by abort.
    assign start_ok = bus.start && !bus.abort &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_vec = (stim_q == STIM_LAST);
    assign mismatch = (bus.dut_out != (^stim_q));

    // Timer reloads at the start of every vector and counts down in SETTLE.
    assign timer_load = start_ok ||
                        ((state_q == ST_CHECK) && !last_vec && !bus.abort);
    assign timer_dec  = (state_q == ST_SETTLE);

    settle_timer #(.W(SETTLE_W)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (bus.start) state_d = ST_SETTLE;
                ST_SETTLE:        if (timer_zero) state_d = ST_CHECK;
                ST_CHECK:         state_d = last_vec ? ST_DONE : ST_SETTLE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        bus.done      = (state_q == ST_DONE);
        bus.pass      = (state_q == ST_DONE) && pass_q;
        bus.dbg_state = state_q;
    end

    // Datapath: stimulus stepping, error accounting and the final verdict.
    // Abort clears stim/pass but keeps err_count/first_fail for inspection.
    always_comb begin
        stim_d       = stim_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        if (bus.abort) begin
            stim_d = '0;
            pass_d = 1'b0;
        end else if (start_ok) begin
            stim_d       = '0;
            err_d        = '0;
            first_fail_d = '0;
            pass_d       = 1'b0;
        end else if (state_q == ST_CHECK) begin
            if (mismatch) begin
                err_d = err_q + (WIDTH+1)'(1);
                if (err_q == '0) begin
                    first_fail_d = stim_q;
                end
            end
            if (last_vec) begin
                pass_d = (err_q == '0) && !mismatch;
            end else begin
                stim_d = stim_q + WIDTH'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_q       <= '0;
            err_q        <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            stim_q       <= stim_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = first_fail_q;

endmodule : gate_test_sequencer
